// File: rtl/diaosi_types_pkg.sv
// Shared pipeline types: the elastic stage state encoding and the
// performance counter width bound.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } pstate_t;

  localparam int PS_CNT_MAX_W = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with 2-entry skid buffer, flush and hold.
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
  import diaosi_types_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
`endif
  output logic [1:0]       dbg_state
);

  if ((WIDTH < 1) || (WIDTH > 1024)) begin : g_bad_width
    $error("pipe_stage_reg: WIDTH out of range");
  end
  if ((CNT_W < 1) || (CNT_W > PS_CNT_MAX_W)) begin : g_bad_cnt_w
    $error("pipe_stage_reg: CNT_W out of range");
  end

  // Handshake: a beat moves on a side only in a cycle where valid and ready
  // are both high at the rising edge; ready never depends on same-side valid.
  pstate_t          state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             acc, deq;

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = (state_q != PS_FULL) && !flush && !RST;
  assign acc       = in_valid && in_ready;
  assign deq       = out_valid && out_ready && !hold;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (acc) begin
            main_d  = in_data;
            state_d = PS_HALF;
          end
        end
        PS_HALF: begin
          if (acc && deq) begin
            main_d = in_data;
          end else if (acc) begin
            skid_d  = in_data;
            state_d = PS_FULL;
          end else if (deq) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (deq) begin
            main_d  = skid_q;
            state_d = PS_HALF;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= PS_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (out_valid && !(out_ready && !hold)),
    .cnt (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (!out_valid),
    .cnt (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, skid, flush (both
// clear modes), hold, and the counters when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         hold;
  logic         in_valid;
  logic         in_ready, in_ready_nc;
  logic [W-1:0] in_data;
  logic         out_valid, out_valid_nc;
  logic         out_ready;
  logic [W-1:0] out_data, out_data_nc;
  logic [1:0]   dbg_state, dbg_state_nc;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]   stall_cnt, bubble_cnt, stall_cnt_nc, bubble_cnt_nc;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  pipe_stage_reg #(.WIDTH(W), .CLEAR_ON_FLUSH(1), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .dbg_state(dbg_state)
  );

  pipe_stage_reg #(.WIDTH(W), .CLEAR_ON_FLUSH(0), .CNT_W(4)) dut_nc (
    .CLK(clk), .RST(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(in_ready_nc), .in_data(in_data),
    .out_valid(out_valid_nc), .out_ready(out_ready), .out_data(out_data_nc),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt(stall_cnt_nc), .bubble_cnt(bubble_cnt_nc),
`endif
    .dbg_state(dbg_state_nc)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and outputs
  // sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid cyc%0d: got %b want 0", c, out_valid);
      else n_pass++;
      n_checks++;
      if (out_data !== 32'h0) $display("FAIL reset_out_data cyc%0d: got %h want 0", c, out_data);
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready cyc%0d: got %b want 0", c, in_ready);
      else n_pass++;
    end
`ifdef PIPE_STAGE_PERF_EN
    n_checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0)
      $display("FAIL reset_counters: got stall=%0d bubble=%0d want 0/0", stall_cnt, bubble_cnt);
    else n_pass++;
`endif
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL stream_in_ready beat%0d: got %b want 1", i, in_ready);
      else n_pass++;
      if (i > 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'(i - 1))
          $display("FAIL stream_out beat%0d: got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, i - 1);
        else n_pass++;
      end else begin
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL stream_first_latency: got v=%b want 0", out_valid);
        else n_pass++;
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd8)
      $display("FAIL stream_last: got v=%b d=%0d want v=1 d=8", out_valid, out_data);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL stream_drain: got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'd1;
    step();
    in_data = 32'd2;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL skid_ready_beat2: got %b want 1", in_ready);
    else n_pass++;
    step();
    in_data = 32'd3;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || dbg_state !== 2'd2)
      $display("FAIL skid_full: got rdy=%b st=%0d want rdy=0 st=2", in_ready, dbg_state);
    else n_pass++;
    step();
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_data !== 32'd1 || in_ready !== 1'b0)
      $display("FAIL skid_head1: got d=%0d rdy=%b want d=1 rdy=0", out_data, in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (out_data !== 32'd2 || in_ready !== 1'b1)
      $display("FAIL skid_head2: got d=%0d rdy=%b want d=2 rdy=1", out_data, in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd3)
      $display("FAIL skid_head3: got v=%b d=%0d want v=1 d=3", out_valid, out_data);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL skid_drain: got v=%b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_data = 32'hC; flush = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 32'hA)
      $display("FAIL flush_cycle: got rdy=%b d=%h want rdy=0 d=a", in_ready, out_data);
    else n_pass++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL flush_clear: got v=%b d=%h want v=0 d=0", out_valid, out_data);
    else n_pass++;
    n_checks++;
    if (out_valid_nc !== 1'b0 || out_data_nc !== 32'hA)
      $display("FAIL flush_retain: got v=%b d=%h want v=0 d=a", out_valid_nc, out_data_nc);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL flush_ready_back: got %b want 1", in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out_valid_nc !== 1'b0)
      $display("FAIL flush_no_accept: got v=%b/%b want 0/0", out_valid, out_valid_nc);
    else n_pass++;
  endtask

  task automatic test_hold();
    out_ready = 1'b1; hold = 1'b1;
    in_valid = 1'b1; in_data = 32'd5;
    step();
    in_data = 32'd6;
    #1;
    n_checks++;
    if (out_data !== 32'd5 || in_ready !== 1'b1)
      $display("FAIL hold_c2: got d=%0d rdy=%b want d=5 rdy=1", out_data, in_ready);
    else n_pass++;
    step();
    in_data = 32'd7;
    #1;
    n_checks++;
    if (out_data !== 32'd5 || in_ready !== 1'b0 || dbg_state !== 2'd2)
      $display("FAIL hold_full: got d=%0d rdy=%b st=%0d want d=5 rdy=0 st=2", out_data, in_ready, dbg_state);
    else n_pass++;
    step();
    hold = 1'b0;
    #1;
    n_checks++;
    if (out_data !== 32'd5) $display("FAIL hold_release_head: got %0d want 5", out_data);
    else n_pass++;
    step();
    n_checks++;
    if (out_data !== 32'd6 || in_ready !== 1'b1)
      $display("FAIL hold_head6: got d=%0d rdy=%b want d=6 rdy=1", out_data, in_ready);
    else n_pass++;
    step();
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd7)
      $display("FAIL hold_head7: got v=%b d=%0d want v=1 d=7", out_valid, out_data);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL hold_drain: got v=%b want 0", out_valid);
    else n_pass++;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) step();
    n_checks++;
    if (bubble_cnt !== 4'd15 || stall_cnt !== 4'd0)
      $display("FAIL perf_bubble_sat: got bubble=%0d stall=%0d want 15/0", bubble_cnt, stall_cnt);
    else n_pass++;
    in_valid = 1'b1; in_data = 32'h55;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) step();
    n_checks++;
    if (stall_cnt !== 4'd3) $display("FAIL perf_stall: got %0d want 3", stall_cnt);
    else n_pass++;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++;
    if (stall_cnt !== 4'd3 || bubble_cnt !== 4'd15)
      $display("FAIL perf_flush_keep: got stall=%0d bubble=%0d want 3/15", stall_cnt, bubble_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_hold();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
